// File: rtl/bpu.sv
// rtl/bpu.sv - branch prediction unit: direct-mapped BTB with 2-bit counters and a return address stack
module bpu #(
   parameter int XLEN      = 64,
   parameter int BTB_IDX_W = 4,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_npc,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ex_is_branch,
   input  logic            ex_is_jump,
   input  logic            ex_is_call,
   input  logic            ex_is_ret,
   input  logic            ex_taken,
   input  logic [XLEN-1:0] ex_target,
   input  logic [XLEN-1:0] ex_pred_npc,
   output logic            mispredict,
   output logic [XLEN-1:0] redirect_pc,
   output logic [31:0]     mispred_cnt
);
   localparam int ENTRIES = 1 << BTB_IDX_W;
   localparam int TAG_W   = XLEN - BTB_IDX_W - 2;
   localparam int RAS_PW  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int RAS_CW  = $clog2(RAS_DEPTH + 1);

   typedef enum logic [1:0] {KIND_BRANCH = 2'd0, KIND_JUMP = 2'd1, KIND_RET = 2'd2} kind_t;

   logic [ENTRIES-1:0]      btb_valid;
   logic [ENTRIES-1:0][1:0] btb_ctr;
   logic [TAG_W-1:0]        btb_tag    [ENTRIES];
   logic [XLEN-1:0]         btb_target [ENTRIES];
   kind_t                   btb_kind   [ENTRIES];

   logic [XLEN-1:0]   ras_mem [RAS_DEPTH];
   logic [RAS_PW-1:0] ras_top;
   logic [RAS_CW-1:0] ras_cnt;
   logic [RAS_PW-1:0] ras_top_inc;
   logic [RAS_PW-1:0] ras_top_dec;
   logic              ras_empty;

   logic [BTB_IDX_W-1:0] f_idx;
   logic [TAG_W-1:0]     f_tag;
   logic                 f_hit;
   logic [XLEN-1:0]      f_seq;
   logic [BTB_IDX_W-1:0] e_idx;
   logic [TAG_W-1:0]     e_tag;
   logic                 e_hit;
   logic [XLEN-1:0]      e_seq;
   logic [XLEN-1:0]      actual_npc;
   logic [1:0]           ctr_inc;
   logic [1:0]           ctr_dec;
   logic                 unused_pc_bits;

   assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

   assign f_idx     = if_pc[BTB_IDX_W+1:2];
   assign f_tag     = if_pc[XLEN-1:BTB_IDX_W+2];
   assign f_hit     = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
   assign f_seq     = if_pc + XLEN'(4);
   assign ras_empty = (ras_cnt == '0);

   always_comb begin
      pred_taken = 1'b0;
      pred_npc   = f_seq;
      if (f_hit) begin
         case (btb_kind[f_idx])
            KIND_JUMP: begin
               pred_taken = 1'b1;
               pred_npc   = btb_target[f_idx];
            end
            KIND_BRANCH: begin
               if (btb_ctr[f_idx][1]) begin
                  pred_taken = 1'b1;
                  pred_npc   = btb_target[f_idx];
               end
            end
            KIND_RET: begin
               if (!ras_empty) begin
                  pred_taken = 1'b1;
                  pred_npc   = ras_mem[ras_top];
               end
            end
            default: ;
         endcase
      end
   end

   assign e_idx       = ex_pc[BTB_IDX_W+1:2];
   assign e_tag       = ex_pc[XLEN-1:BTB_IDX_W+2];
   assign e_hit       = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag);
   assign e_seq       = ex_pc + XLEN'(4);
   assign actual_npc  = ex_taken ? ex_target : e_seq;
   assign mispredict  = ex_valid && !rst && (actual_npc != ex_pred_npc);
   assign redirect_pc = actual_npc;
   assign ctr_inc     = (btb_ctr[e_idx] == 2'b11) ? 2'b11 : btb_ctr[e_idx] + 2'b01;
   assign ctr_dec     = (btb_ctr[e_idx] == 2'b00) ? 2'b00 : btb_ctr[e_idx] - 2'b01;

   always_ff @(posedge clk) begin
      if (rst) begin
         btb_valid <= '0;
         btb_ctr   <= '0;
      end else if (ex_valid) begin
         if (ex_is_jump) begin
            btb_valid[e_idx]  <= 1'b1;
            btb_tag[e_idx]    <= e_tag;
            btb_target[e_idx] <= ex_target;
            btb_kind[e_idx]   <= ex_is_ret ? KIND_RET : KIND_JUMP;
            btb_ctr[e_idx]    <= 2'b11;
         end else if (ex_is_branch) begin
            if (e_hit) begin
               btb_ctr[e_idx]  <= ex_taken ? ctr_inc : ctr_dec;
               btb_kind[e_idx] <= KIND_BRANCH;
               if (ex_taken) begin
                  btb_target[e_idx] <= ex_target;
               end
            end else if (ex_taken) begin
               btb_valid[e_idx]  <= 1'b1;
               btb_tag[e_idx]    <= e_tag;
               btb_target[e_idx] <= ex_target;
               btb_kind[e_idx]   <= KIND_BRANCH;
               btb_ctr[e_idx]    <= 2'b10;
            end
         end
      end
   end

   // Circular stack: a push when full silently overwrites the oldest slot.
   assign ras_top_inc = (ras_top == RAS_PW'(RAS_DEPTH - 1)) ? '0 : ras_top + RAS_PW'(1);
   assign ras_top_dec = (ras_top == '0) ? RAS_PW'(RAS_DEPTH - 1) : ras_top - RAS_PW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         ras_top <= '0;
         ras_cnt <= '0;
      end else if (ex_valid) begin
         if (ex_is_call && ex_is_ret && !ras_empty) begin
            ras_mem[ras_top] <= e_seq;
         end else if (ex_is_call) begin
            ras_top              <= ras_top_inc;
            ras_mem[ras_top_inc] <= e_seq;
            if (ras_cnt != RAS_CW'(RAS_DEPTH)) begin
               ras_cnt <= ras_cnt + RAS_CW'(1);
            end
         end else if (ex_is_ret && !ras_empty) begin
            ras_top <= ras_top_dec;
            ras_cnt <= ras_cnt - RAS_CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mispred_cnt <= '0;
      end else if (mispredict) begin
         mispred_cnt <= mispred_cnt + 32'd1;
      end
   end
endmodule
